arb_4_64bit: RTL and testbench



---
 rtl/arb_4_64bit.sv | 137 +++++++++++++
 tb/tb_arb_4_64bit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/arb_4_64bit.sv
// rtl/arb_4_64bit.sv - four-requester round-robin arbiter with a registered 64-bit output stage
// Optional macro ARB_LOCK_EN adds i_lock so a locked requester keeps winning for multi-beat bursts.
module arb_4_64bit #(
  parameter int WIDTH = 64
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [3:0]       i_req,
  input  logic [WIDTH-1:0] i_data0,
  input  logic [WIDTH-1:0] i_data1,
  input  logic [WIDTH-1:0] i_data2,
  input  logic [WIDTH-1:0] i_data3,
`ifdef ARB_LOCK_EN
  input  logic [3:0]       i_lock,
`endif
  output logic [3:0]       o_grant,
  output logic [1:0]       o_select,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data
);

  typedef enum logic {ST_IDLE, ST_FULL} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_last;
  logic [1:0]       r_sel;
  logic [WIDTH-1:0] r_out_data;
  logic [1:0]       w_rr;
  logic [1:0]       w_idx;
  logic             w_found;
  logic [1:0]       w_winner;
  logic             w_any;
  logic             w_can_take;
  logic             w_capture;
  logic [WIDTH-1:0] w_mux;

  // Search last+1 .. last+4; the 2-bit add wraps, so the final slot is last itself.
  always_comb begin
    w_rr    = r_last;
    w_idx   = r_last;
    w_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last + 2'(k);
      if (!w_found && i_req[w_idx]) begin
        w_rr    = w_idx;
        w_found = 1'b1;
      end
    end
  end

`ifdef ARB_LOCK_EN
  logic r_lock_hold;

  assign w_winner = (r_lock_hold && i_req[r_last]) ? r_last : w_rr;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_lock_hold <= 1'b0;
    end else if (w_capture) begin
      r_lock_hold <= i_lock[w_winner];
    end else if (!i_req[r_last]) begin
      r_lock_hold <= 1'b0;
    end
  end
`else
  assign w_winner = w_rr;
`endif

  assign w_any      = |i_req;
  assign w_can_take = (r_state == ST_IDLE) || i_out_ready;
  assign w_capture  = !i_reset && w_can_take && w_any;

  always_comb begin
    w_state_nxt = r_state;
    o_grant     = 4'b0000;
    o_select    = r_sel;
    if (i_reset) begin
      o_select = 2'd0;
    end else if (w_any) begin
      o_select = w_winner;
    end
    if (w_capture) begin
      o_grant = 4'b0001 << w_winner;
    end
    case (r_state)
      ST_IDLE: begin
        if (w_capture) begin
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        // Accepting and capturing in the same cycle keeps the stage full.
        if (!w_capture && i_out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    case (o_select)
      2'd0:    w_mux = i_data0;
      2'd1:    w_mux = i_data1;
      2'd2:    w_mux = i_data2;
      default: w_mux = i_data3;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_out_data <= '0;
      r_last     <= 2'd3;
      r_sel      <= 2'd0;
    end else begin
      r_sel <= o_select;
      if (w_capture) begin
        r_out_data <= w_mux;
        r_last     <= w_winner;
      end
    end
  end

  assign o_out_valid = (r_state == ST_FULL);
  assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_arb_4_64bit.sv
// tb/tb_arb_4_64bit.sv - randomized self-checking bench for arb_4_64bit against a behavioural model
module tb_arb_4_64bit;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [W-1:0]  d [4];
  logic [W-1:0]  nd [4];
  logic          rdy;
  logic [3:0]    lock = 4'b0000;
  logic [3:0]    o_grant;
  logic [1:0]    o_select;
  logic          o_out_valid;
  logic [W-1:0]  o_out_data;

  int n_chk  = 0;
  int n_pass = 0;

  int           m_last = 3;
  bit           m_full = 1'b0;
  logic [W-1:0] m_data = '0;
  int           m_sel  = 0;
  logic [3:0]   m_gnt  = 4'b0000;

  logic [3:0]   pend;

  always #5 clk = ~clk;

  arb_4_64bit #(.WIDTH(W)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_req       (req),
    .i_data0     (d[0]),
    .i_data1     (d[1]),
    .i_data2     (d[2]),
    .i_data3     (d[3]),
`ifdef ARB_LOCK_EN
    .i_lock      (lock),
`endif
    .o_grant     (o_grant),
    .o_select    (o_select),
    .o_out_valid (o_out_valid),
    .i_out_ready (rdy),
    .o_out_data  (o_out_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  // Drives one cycle's inputs, checks outputs mid-cycle, then advances the model across the next edge.
  task automatic step(input logic r, input logic [3:0] q, input logic rd, input bit chk_out);
    int win;
    int idx;
    int exp_sel;
    logic [3:0] exp_gnt;
    @(posedge clk);
    #1;
    rst = r;
    req = q;
    rdy = rd;
    d   = nd;
    #4;
    win = -1;
    for (int k = 1; k <= 4; k++) begin
      idx = (m_last + k) % 4;
      if (q[idx] && win < 0) win = idx;
    end
    if (r) begin
      exp_sel = 0;
      exp_gnt = 4'b0000;
    end else begin
      exp_sel = (win >= 0) ? win : m_sel;
      exp_gnt = ((!m_full || rd) && win >= 0) ? (4'b0001 << win) : 4'b0000;
    end
    check("grant", o_grant, exp_gnt);
    check("select", o_select, exp_sel);
    if (chk_out) begin
      check("out_valid", o_out_valid, m_full);
      check("out_data", o_out_data, m_data);
    end
    m_gnt = exp_gnt;
    if (r) begin
      m_last = 3;
      m_full = 1'b0;
      m_data = '0;
      m_sel  = 0;
    end else begin
      m_sel = exp_sel;
      if (exp_gnt != 4'b0000) begin
        m_data = d[win];
        m_last = win;
        m_full = 1'b1;
      end else if (m_full && rd) begin
        m_full = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d[i]  = '0;
      nd[i] = '0;
    end

    step(1'b1, 4'hF, 1'b1, 1'b0);
    check("rst_grant0", o_grant, 4'b0000);
    step(1'b1, 4'hF, 1'b1, 1'b1);
    check("rst_valid", o_out_valid, 1'b0);
    check("rst_data", o_out_data, 64'd0);

    for (int i = 0; i < 4; i++) nd[i] = 64'(i + 1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'hF, 1'b1, 1'b1);
      check("fair_grant", o_grant, 4'b0001 << (i % 4));
    end
    step(1'b0, 4'h0, 1'b1, 1'b1);
    check("fair_last_data", o_out_data, 64'd4);
    step(1'b0, 4'h0, 1'b1, 1'b1);
    check("drained", o_out_valid, 1'b0);

    nd[2] = 64'hDEAD_BEEF_0000_0002;
    step(1'b0, 4'b0100, 1'b1, 1'b1);
    check("single_grant", o_grant, 4'b0100);
    check("single_sel", o_select, 2'd2);
    step(1'b0, 4'b0000, 1'b1, 1'b1);
    check("single_valid", o_out_valid, 1'b1);
    check("single_data", o_out_data, 64'hDEAD_BEEF_0000_0002);

    nd[0] = 64'd5;
    step(1'b0, 4'b0001, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'b0011, 1'b0, 1'b1);
      check("bp_grant", o_grant, 4'b0000);
      check("bp_data", o_out_data, 64'd5);
    end
    step(1'b0, 4'b0011, 1'b1, 1'b1);
    check("bp_resume", o_grant, 4'b0010);

    step(1'b0, 4'b0000, 1'b0, 1'b1);
    check("mid_full", o_out_valid, 1'b1);
    step(1'b1, 4'b0000, 1'b0, 1'b1);
    step(1'b0, 4'b0110, 1'b1, 1'b1);
    check("mid_valid", o_out_valid, 1'b0);
    check("mid_grant", o_grant, 4'b0010);

    pend = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (m_gnt[i]) begin
          pend[i] = 1'b0;
        end else if (!pend[i] && ($urandom % 3) == 0) begin
          pend[i] = 1'b1;
          nd[i]   = {$urandom, $urandom};
        end else if (pend[i] && ($urandom % 50) == 0) begin
          pend[i] = 1'b0;
        end
      end
      step(($urandom % 100) == 0, pend, ($urandom % 4) != 0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
